// File: rtl/mem_cycle_sequencer_if.sv
// Bus between the I/E-cycle control logic (master) and the memory-cycle
// sequencer (slave). The master raises requests and halt. The sequencer
// returns the grant, the cycle timing and the trigger-latch pulses.
interface mem_cycle_sequencer_if #(
  parameter int PHASES = 10
);
  logic [1:0]        req;
  logic              halt;
  logic [1:0]        gnt;
  logic              busy;
  logic [3:0]        phase;
  logic [PHASES-1:0] tp;
  logic              trig_set_n;
  logic              trig_rst_n;
  logic              done;

  modport master (
    output req, halt,
    input  gnt, busy, phase, tp, trig_set_n, trig_rst_n, done
  );

  modport slave (
    input  req, halt,
    output gnt, busy, phase, tp, trig_set_n, trig_rst_n, done
  );
endinterface

// File: rtl/mem_cycle_sequencer.sv
// Core-memory cycle sequencer.
// - Arbitrates memory cycles round-robin between the CPU (0) and the console (1).
// - Walks each granted cycle through PHASES timing pulses of CLKS_PER_PHASE clocks.
// - Fires active-low set/reset pulses for the memory-cycle trigger latch.
// Every output is a register. Each branch loads the value that output must
// show during the next clock.
module mem_cycle_sequencer #(
  parameter int PHASES         = 10,
  parameter int CLKS_PER_PHASE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_cycle_sequencer_if.slave bus
);

  localparam int               SUB_W     = (CLKS_PER_PHASE > 1) ? $clog2(CLKS_PER_PHASE) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX   = SUB_W'(CLKS_PER_PHASE - 1);
  localparam logic [3:0]       PHASE_MAX = 4'(PHASES - 1);
  localparam logic [PHASES-1:0] TP_FIRST = {{(PHASES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            r_state;
  logic [SUB_W-1:0]  r_sub;
  logic [3:0]        r_phase;
  logic              r_last;
  logic [1:0]        r_gnt;
  logic              r_busy;
  logic [PHASES-1:0] r_tp;
  logic              r_set_n;
  logic              r_rst_n;
  logic              r_done;

  logic              w_last_clk;
  logic              w_pick;
  logic [1:0]        w_pick_gnt;

  // Final clock of the current cycle (last phase, last sub-clock).
  assign w_last_clk = (r_phase == PHASE_MAX) && (r_sub == SUB_MAX);

  // Round-robin choice: on a tie, serve the requester that was not served last.
  assign w_pick     = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_pick_gnt = w_pick ? 2'b10 : 2'b01;

  // Cycle FSM with all outputs registered alongside the state.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and the order of statements inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sub   <= '0;
      r_phase <= '0;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_tp    <= '0;
      r_set_n <= 1'b1;
      r_rst_n <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (r_state == HALTED) begin
            // A grant is never issued in the same clock that halt is released.
            if (!bus.halt) r_state <= IDLE;
          end else if (bus.halt) begin
            r_state <= HALTED;
          end else if (bus.req != 2'b00) begin
            r_state <= RUN;
            r_gnt   <= w_pick_gnt;
            r_last  <= w_pick;
            r_busy  <= 1'b1;
            r_phase <= '0;
            r_sub   <= '0;
            r_tp    <= TP_FIRST;
            r_set_n <= 1'b0;
            r_rst_n <= 1'b1;
            r_done  <= 1'b0;
          end
        end

        RUN: begin
          if (w_last_clk) begin
            // Cycle boundary: halt wins over a pending request.
            if (!bus.halt && bus.req != 2'b00) begin
              r_state <= RUN;
              r_gnt   <= w_pick_gnt;
              r_last  <= w_pick;
              r_busy  <= 1'b1;
              r_tp    <= TP_FIRST;
              r_set_n <= 1'b0;
            end else begin
              r_state <= bus.halt ? HALTED : IDLE;
              r_gnt   <= 2'b00;
              r_busy  <= 1'b0;
              r_tp    <= '0;
              r_set_n <= 1'b1;
            end
            r_phase <= '0;
            r_sub   <= '0;
            r_rst_n <= 1'b1;
            r_done  <= 1'b0;
          end else if (r_sub == SUB_MAX) begin
            // Phase step. With CLKS_PER_PHASE >= 2 the new phase never starts on its last clock.
            r_sub   <= '0;
            r_phase <= r_phase + 4'd1;
            r_tp    <= r_tp << 1;
            r_set_n <= 1'b1;
            r_rst_n <= !((r_phase + 4'd1) == PHASE_MAX);
            r_done  <= 1'b0;
          end else begin
            r_sub   <= r_sub + SUB_W'(1);
            r_set_n <= 1'b1;
            r_rst_n <= 1'b1;
            r_done  <= (r_phase == PHASE_MAX) && ((r_sub + SUB_W'(1)) == SUB_MAX);
          end
        end

        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_tp    <= '0;
          r_set_n <= 1'b1;
          r_rst_n <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.busy       = r_busy;
  assign bus.phase      = r_phase;
  assign bus.tp         = r_tp;
  assign bus.trig_set_n = r_set_n;
  assign bus.trig_rst_n = r_rst_n;
  assign bus.done       = r_done;

endmodule
